// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU issue arbiter.
// No logic here; widths default the top-level XLEN/TAG_W parameters.
// No flow control of its own.
package alu_arb_pkg;

    localparam int REQ_N     = 2;
    localparam int ARB_XLEN  = 32;
    localparam int ARB_TAG_W = 3;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [3:0]           funct;
        logic [1:0]           aluop;
        logic [ARB_XLEN-1:0]  a;
        logic [ARB_XLEN-1:0]  b;
        logic [ARB_TAG_W-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, restricted to the lock owner while locked.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller qualifies grant with its advance signal.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [REQ_N-1:0] valid,
    input  logic             last_grant,
    input  lock_state_e      lock_st,
    output logic [REQ_N-1:0] grant
);

    always_comb begin
        grant = '0;
        case (lock_st)
            LOCK0:   grant[0] = valid[0];
            LOCK1:   grant[1] = valid[1];
            default: begin
                if (valid[0] && valid[1]) begin
                    // the requester not served last time wins contention
                    if (last_grant) grant[0] = 1'b1;
                    else            grant[1] = 1'b1;
                end else begin
                    grant = valid;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between two request streams with RR + lock; ALU_ARB_PERF_EN adds perf counters.
// Latency: accept at edge N -> resp_valid after edge N+1, 1 op/cycle when resp_ready is held.
// Backpressure: a stalled result register freezes both stages and drops both req readys.
module alu_issue_arbiter
    import alu_arb_pkg::*;
#(
    parameter int XLEN     = ARB_XLEN,
    parameter int TAG_W    = ARB_TAG_W,
    parameter int LOCK_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_lock,
    input  logic [3:0]       req0_funct,
    input  logic [1:0]       req0_aluop,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_lock,
    input  logic [3:0]       req1_funct,
    input  logic [1:0]       req1_aluop,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [3:0]       alu_funct,
    output logic [1:0]       alu_aluop,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [XLEN-1:0]  resp_data
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_e      lock_st, lock_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             last_grant, last_grant_nxt;

    logic             issue_v;
    logic             issue_id;
    logic [TAG_W-1:0] issue_tag;

    logic             adv;
    logic [REQ_N-1:0] req_valid;
    logic [REQ_N-1:0] grant;
    alu_req_t         req [REQ_N];
    alu_req_t         req_sel;
    logic             acc0, acc1, acc, acc_id, acc_lock;

    assign req[0] = '{funct: req0_funct, aluop: req0_aluop, a: req0_a, b: req0_b, tag: req0_tag};
    assign req[1] = '{funct: req1_funct, aluop: req1_aluop, a: req1_a, b: req1_b, tag: req1_tag};
    assign req_valid = {req1_valid, req0_valid};

    assign adv = !resp_valid || resp_ready;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant),
        .lock_st    (lock_st),
        .grant      (grant)
    );

    assign req0_ready = !rst && adv && grant[0];
    assign req1_ready = !rst && adv && grant[1];
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc        = acc0 || acc1;
    assign acc_id     = acc1;
    assign acc_lock   = acc1 ? req1_lock : req0_lock;
    assign req_sel    = acc1 ? req[1] : req[0];

    always_comb begin
        lock_nxt       = lock_st;
        lock_cnt_nxt   = lock_cnt;
        last_grant_nxt = last_grant;
        if (acc) begin
            last_grant_nxt = acc_id;
            if (!acc_lock || (int'(lock_cnt) + 1 >= LOCK_MAX)) begin
                // an exhausted lock releases with last_grant on the owner, so the other side wins next
                lock_nxt     = FREE;
                lock_cnt_nxt = '0;
            end else begin
                lock_nxt     = acc_id ? LOCK1 : LOCK0;
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st    <= FREE;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            lock_st    <= lock_nxt;
            lock_cnt   <= lock_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_v    <= 1'b0;
            issue_id   <= 1'b0;
            issue_tag  <= '0;
            alu_funct  <= '0;
            alu_aluop  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else if (adv) begin
            resp_valid <= issue_v;
            resp_id    <= issue_id;
            resp_tag   <= issue_tag;
            resp_data  <= alu_result;
            issue_v    <= acc;
            if (acc) begin
                issue_id  <= acc_id;
                issue_tag <= req_sel.tag;
                alu_funct <= req_sel.funct;
                alu_aluop <= req_sel.aluop;
                alu_a     <= req_sel.a;
                alu_b     <= req_sel.b;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (acc0)                      perf_grant0 <= perf_grant0 + 32'd1;
            if (acc1)                      perf_grant1 <= perf_grant1 + 32'd1;
            if (resp_valid && !resp_ready) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
